// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/stall control logic. This package
// is also used by the ID/EX stage logic, which decodes the load-use forward
// selects and the how-many-operands field.
//   pipe_state_t : sequencer FSM states (RUN / LSTALL / REDIR / MWAIT)
//   LU_*         : load-use forward select encodings
//   OPS_*        : how_many_ops encodings (3 behaves like OPS_RS_RT)
//   uses_rs/rt   : decode helpers for how_many_ops
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_REDIR  = 2'd2,
    ST_MWAIT  = 2'd3
  } pipe_state_t;

  localparam logic [1:0] LU_NONE  = 2'b00;
  localparam logic [1:0] LU_MEMWB = 2'b01;

  localparam logic [1:0] OPS_NONE  = 2'd0;
  localparam logic [1:0] OPS_RS    = 2'd1;
  localparam logic [1:0] OPS_RS_RT = 2'd2;

  // True when the instruction in ID reads rs (any operand count >= 1)
  function automatic logic uses_rs(input logic [1:0] ops);
    return ops >= OPS_RS;
  endfunction

  // True when the instruction in ID also reads rt (count 2, or 3 treated as 2)
  function automatic logic uses_rt(input logic [1:0] ops);
    return ops >= OPS_RS_RT;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the performance counters. Counts cycles with
// inc=1 and sticks at all-ones instead of wrapping.
//   clk   in  : clock, rising edge
//   rst   in  : asynchronous active-high reset, clears the count
//   inc   in  : count this cycle
//   clear in  : synchronous clear (wins over inc)
//   count out : current count, W bits
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  // Count up on inc, but hold once every bit is set so the value never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// ---------------------------------------------------------------------------
// pipe_hazard_sequencer
// Central stall/flush controller for the 5-stage pipeline. Detects load-use
// hazards, branch/jump redirects and data-memory busy, sequences bubbles and
// flushes, and produces registered load-use forward selects.
//   clk, rst          : clock / asynchronous active-high reset
//   id_rs, id_rt      : source registers of the instruction in ID
//   id_how_many_ops   : number of register sources used by ID
//   ex_load_signal    : EX holds a load
//   ex_rt             : destination of the load in EX
//   ex_branch_taken   : branch in EX resolved taken
//   ex_jump           : nonzero when EX holds a jump
//   mem_busy          : data memory not ready, whole pipeline freezes
//   stall_pc          : hold PC
//   stall_if_id       : hold IF/ID
//   flush_if_id       : zero IF/ID controls
//   flush_id_ex       : zero ID/EX controls (bubble)
//   freeze            : hold all pipeline registers
//   load_useA/B       : forward select for operand A/B (LU_NONE / LU_MEMWB)
//   state_o           : current FSM state for debug
//   stall_cnt         : saturating count of stall_pc cycles
//   flush_cnt         : saturating count of flush_id_ex cycles
// ---------------------------------------------------------------------------
module pipe_hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_STALL   = 1,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [1:0]        id_how_many_ops,
  input  logic              ex_load_signal,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_branch_taken,
  input  logic [1:0]        ex_jump,
  input  logic              mem_busy,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              freeze,
  output logic [1:0]        load_useA,
  output logic [1:0]        load_useB,
  output logic [1:0]        state_o,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam int CMAX = (FLUSH_CYCLES > LOAD_STALL) ? FLUSH_CYCLES : LOAD_STALL;
  localparam int CW   = $clog2(CMAX + 1);

  pipe_state_t   state, nxt_state;
  pipe_state_t   saved_state, nxt_saved;
  pipe_state_t   eff;
  logic [CW-1:0] cnt, nxt_cnt;
  logic          pend_redir, nxt_pend;
  logic          match_a, match_b, nxt_match_a, nxt_match_b;
  logic          last_bubble;
  logic          force_redir;
  logic          match_rs, match_rt, lu_hit, redir;

  // Hazard detection; a load into r0 never creates a dependency
  assign match_rs = uses_rs(id_how_many_ops) && (id_rs == ex_rt);
  assign match_rt = uses_rt(id_how_many_ops) && (id_rt == ex_rt);
  assign lu_hit   = ex_load_signal && (ex_rt != '0) && (match_rs || match_rt);
  assign redir    = ex_branch_taken || (ex_jump != 2'b00);

  assign state_o  = state;

  // Next-state and control outputs. When MWAIT releases, the cycle behaves as
  // the first cycle of the state it returns to (or of a fresh redirect if one
  // was seen during the wait), so the pipeline never advances unprotected.
  // The cnt register holds the remaining LSTALL/REDIR cycles including the
  // current one. Outputs are forced low while rst is asserted.
  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    freeze      = 1'b0;
    nxt_state   = state;
    nxt_saved   = saved_state;
    nxt_cnt     = cnt;
    nxt_pend    = pend_redir;
    nxt_match_a = match_a;
    nxt_match_b = match_b;
    last_bubble = 1'b0;
    force_redir = 1'b0;
    eff         = state;

    if (!rst) begin
      if (state == ST_MWAIT) begin
        if (mem_busy) begin
          freeze   = 1'b1;
          nxt_pend = pend_redir | redir;
        end else begin
          eff         = pend_redir ? ST_RUN : saved_state;
          force_redir = pend_redir;
          nxt_pend    = 1'b0;
        end
      end

      case (eff)
        ST_RUN: begin
          if (mem_busy) begin
            freeze    = 1'b1;
            nxt_pend  = redir;
            nxt_saved = ST_RUN;
            nxt_state = ST_MWAIT;
          end else if (redir || force_redir) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            nxt_match_a = 1'b0;
            nxt_match_b = 1'b0;
            if (FLUSH_CYCLES > 1) begin
              nxt_state = ST_REDIR;
              nxt_cnt   = CW'(FLUSH_CYCLES - 1);
            end else begin
              nxt_state = ST_RUN;
            end
          end else if (lu_hit) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
            nxt_match_a = match_rs;
            nxt_match_b = match_rt;
            if (LOAD_STALL > 1) begin
              nxt_state = ST_LSTALL;
              nxt_cnt   = CW'(LOAD_STALL - 1);
            end else begin
              nxt_state   = ST_RUN;
              last_bubble = 1'b1;
            end
          end else begin
            nxt_state = ST_RUN;
          end
        end

        ST_LSTALL: begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (redir && !mem_busy) begin
            // Redirect cancels the remaining bubbles and the pending selects
            nxt_state   = ST_REDIR;
            nxt_cnt     = CW'(FLUSH_CYCLES);
            nxt_match_a = 1'b0;
            nxt_match_b = 1'b0;
          end else begin
            nxt_cnt     = cnt - CW'(1);
            last_bubble = (cnt == CW'(1)) && !redir;
            if (mem_busy) begin
              nxt_state = ST_MWAIT;
              nxt_saved = (cnt == CW'(1)) ? ST_RUN : ST_LSTALL;
              nxt_pend  = redir;
            end else begin
              nxt_state = (cnt == CW'(1)) ? ST_RUN : ST_LSTALL;
            end
          end
        end

        ST_REDIR: begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          nxt_cnt     = cnt - CW'(1);
          if (mem_busy) begin
            nxt_state = ST_MWAIT;
            nxt_saved = (cnt == CW'(1)) ? ST_RUN : ST_REDIR;
            nxt_pend  = 1'b0;
          end else begin
            nxt_state = (cnt == CW'(1)) ? ST_RUN : ST_REDIR;
          end
        end

        default: begin
        end
      endcase
    end
  end

  // State, count and latch registers plus the registered forward selects.
  // A select pulses for one cycle after the final bubble and is held, not
  // consumed, while the pipeline is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      saved_state <= ST_RUN;
      cnt         <= '0;
      pend_redir  <= 1'b0;
      match_a     <= 1'b0;
      match_b     <= 1'b0;
      load_useA   <= LU_NONE;
      load_useB   <= LU_NONE;
    end else begin
      state       <= nxt_state;
      saved_state <= nxt_saved;
      cnt         <= nxt_cnt;
      pend_redir  <= nxt_pend;
      match_a     <= nxt_match_a;
      match_b     <= nxt_match_b;
      if (!freeze) begin
        if (last_bubble) begin
          load_useA <= nxt_match_a ? LU_MEMWB : LU_NONE;
          load_useB <= nxt_match_b ? LU_MEMWB : LU_NONE;
        end else begin
          load_useA <= LU_NONE;
          load_useB <= LU_NONE;
        end
      end
    end
  end

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_pc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_id_ex),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule
